// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_NOT = 3'b100,
    OP_OR  = 3'b101,
    OP_CMP = 3'b110,
    OP_BR  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int SUM_W = 9;

  // Operation captured at the accept edge.
  typedef struct packed {
    logic       id;
    logic [2:0] instr;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] baddr;
  } op_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU; eq_in is the owning requester's stored compare bit.
module alu_core
  import alu_pkg::*;
(
  input  logic [2:0] instr,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [5:0] baddr,
  input  logic       eq_in,
  output logic [7:0] out,
  output logic       co,
  output logic       eq,
  output logic       branch
);

  logic [SUM_W-1:0] sum;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    out    = '0;
    co     = 1'b0;
    eq     = 1'b0;
    branch = 1'b0;
    sum    = '0;
    case (opcode_e'(instr))
      OP_ADD: begin
        sum       = {1'b0, A} + {1'b0, B};
        {co, out} = sum;
      end
      OP_SUB: begin
        sum       = {1'b0, A} - {1'b0, B};
        {co, out} = sum;
      end
      OP_AND: out = A & B;
      OP_NOT: out = ~A;
      OP_OR:  out = A | B;
      OP_CMP: begin
        eq  = (A == B);
        out = {7'b0, eq};
      end
      OP_BR: begin
        branch = 1'b1;
        out    = eq_in ? {2'b00, baddr} : 8'h00;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU: accept, execute, then hold
// the registered response until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_instr,
  input  logic [7:0] req0_A,
  input  logic [7:0] req0_B,
  input  logic [5:0] req0_baddr,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_instr,
  input  logic [7:0] req1_A,
  input  logic [7:0] req1_B,
  input  logic [5:0] req1_baddr,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_out,
  output logic       resp_co,
  output logic       resp_eq,
  output logic       resp_branch
);

  state_e     state, state_nxt;
  op_t        op_q;
  logic       ptr;
  logic [1:0] eq_bits;
  logic       grant_id;
  logic       accept;

  logic [7:0] core_out;
  logic       core_co, core_eq, core_branch;

  // Pointer only breaks ties; a lone valid requester always wins.
  assign grant_id = (req0_valid && req1_valid) ? ptr : req1_valid;
  assign accept   = req0_ready || req1_ready;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && !grant_id;
          req1_ready = req1_valid &&  grant_id;
        end
        if (req0_ready || req1_ready) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  alu_core u_core (
    .instr  (op_q.instr),
    .A      (op_q.a),
    .B      (op_q.b),
    .baddr  (op_q.baddr),
    .eq_in  (eq_bits[op_q.id]),
    .out    (core_out),
    .co     (core_co),
    .eq     (core_eq),
    .branch (core_branch)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= '0;
      ptr         <= 1'b0;
      eq_bits     <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_out    <= '0;
      resp_co     <= 1'b0;
      resp_eq     <= 1'b0;
      resp_branch <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= grant_id ? op_t'{1'b1, req1_instr, req1_A, req1_B, req1_baddr}
                         : op_t'{1'b0, req0_instr, req0_A, req0_B, req0_baddr};
        ptr  <= RR_EN ? !grant_id : 1'b0;
      end
      if (state == EXEC) begin
        resp_valid  <= 1'b1;
        resp_id     <= op_q.id;
        resp_out    <= core_out;
        resp_co     <= core_co;
        resp_eq     <= core_eq;
        resp_branch <= core_branch;
        // Compare refreshes the owner's bit; anything else clears it.
        eq_bits[op_q.id] <= (opcode_e'(op_q.instr) == OP_CMP) && core_eq;
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed operations push expected
// responses; a monitor pops and compares on each response handshake.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_instr = '0, req1_instr = '0;
  logic [7:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic [5:0] req0_baddr = '0, req1_baddr = '0;
  logic       resp_valid, resp_ready = 1'b1, resp_id;
  logic [7:0] resp_out;
  logic       resp_co, resp_eq, resp_branch;

  // Fixed-priority instance, both requesters permanently valid.
  logic       fp_req0_ready, fp_req1_ready;
  logic       fp_resp_valid, fp_resp_id, fp_resp_co, fp_resp_eq, fp_resp_branch;
  logic [7:0] fp_resp_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
    .req0_A(req0_A), .req0_B(req0_B), .req0_baddr(req0_baddr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
    .req1_A(req1_A), .req1_B(req1_B), .req1_baddr(req1_baddr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_co(resp_co), .resp_eq(resp_eq),
    .resp_branch(resp_branch)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(1'b1), .req0_ready(fp_req0_ready), .req0_instr(3'b001),
    .req0_A(8'h10), .req0_B(8'h01), .req0_baddr(6'h00),
    .req1_valid(1'b1), .req1_ready(fp_req1_ready), .req1_instr(3'b101),
    .req1_A(8'h0F), .req1_B(8'hF0), .req1_baddr(6'h00),
    .resp_valid(fp_resp_valid), .resp_ready(1'b1), .resp_id(fp_resp_id),
    .resp_out(fp_resp_out), .resp_co(fp_resp_co), .resp_eq(fp_resp_eq),
    .resp_branch(fp_resp_branch)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic expect_resp(input logic id, input logic [7:0] out, input logic co,
                             input logic eq, input logic br);
    sb.push_back({id, out, co, eq, br});
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic id, input logic [2:0] instr, input logic [7:0] a,
                       input logic [7:0] b, input logic [5:0] baddr);
    bit got = 1'b0;
    if (id == 1'b0) begin
      req0_instr = instr; req0_A = a; req0_B = b; req0_baddr = baddr; req0_valid = 1'b1;
    end else begin
      req1_instr = instr; req1_A = a; req1_B = b; req1_baddr = baddr; req1_valid = 1'b1;
    end
    for (int i = 0; i < 64 && !got; i++) begin
      #1;
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) got = 1'b1;
      else @(negedge clk);
    end
    check("accept_seen", {31'b0, got}, 32'd1);
    if (got) @(posedge clk);
    #1;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: response handshakes against the scoreboard, plus accept-to-valid latency.
  initial begin : monitor
    int   acc_cyc = 0;
    bit   pending = 1'b0;
    logic prev_rv = 1'b0;
    logic [11:0] exp_r;
    forever begin
      @(negedge clk);
      #2;
      if (rst) pending = 1'b0;
      else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acc_cyc = cyc;
        pending = 1'b1;
      end
      if (resp_valid && !prev_rv && pending) begin
        check("latency", cyc - acc_cyc, 32'd2);
        pending = 1'b0;
      end
      prev_rv = resp_valid;
      if (resp_valid && resp_ready) begin
        check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_r = sb.pop_front();
          check("resp", {20'b0, resp_id, resp_out, resp_co, resp_eq, resp_branch},
                {20'b0, exp_r});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
  endtask

  initial begin : stim
    int fp_grants = 0;
    // Both requesters valid while in reset.
    req0_instr = 3'b001; req0_A = 8'hF0; req0_B = 8'h20; req0_valid = 1'b1;
    req1_instr = 3'b001; req1_A = 8'h01; req1_B = 8'h02; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
    check("rst_resp", {19'b0, resp_valid, resp_id, resp_out, resp_co, resp_eq, resp_branch}, 32'd0);
    check("rst_fp_ready", {30'b0, fp_req0_ready, fp_req1_ready}, 32'd0);
    @(negedge clk);

    // Round-robin contention: grants 0,1,0,1.
    expect_resp(1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
    expect_resp(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    expect_resp(1'b0, 8'h0C, 1'b0, 1'b0, 1'b0);
    expect_resp(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    fork
      begin
        issue(1'b0, 3'b001, 8'hF0, 8'h20, 6'h00);
        issue(1'b0, 3'b011, 8'h0F, 8'h3C, 6'h00);
      end
      begin
        issue(1'b1, 3'b001, 8'h01, 8'h02, 6'h00);
        issue(1'b1, 3'b101, 8'h50, 8'h05, 6'h00);
      end
    join
    drain();

    // Fixed priority: requester 0 always wins.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      if (fp_req0_ready || fp_req1_ready) begin
        check("fp_grant", {30'b0, fp_req1_ready, fp_req0_ready}, 32'd1);
        fp_grants++;
      end
      if (fp_resp_valid)
        check("fp_resp", {20'b0, fp_resp_id, fp_resp_out, fp_resp_co, fp_resp_eq, fp_resp_branch},
              {20'b0, 1'b0, 8'h11, 3'b000});
    end
    check("fp_grant_count", {31'b0, fp_grants >= 3}, 32'd1);
    @(negedge clk);

    // Compare / branch isolation and remaining opcodes.
    expect_resp(1'b0, 8'h01, 1'b0, 1'b1, 1'b0); issue(1'b0, 3'b110, 8'h33, 8'h33, 6'h00);
    expect_resp(1'b1, 8'h00, 1'b0, 1'b0, 1'b1); issue(1'b1, 3'b111, 8'h00, 8'h00, 6'h2A);
    expect_resp(1'b0, 8'h2A, 1'b0, 1'b0, 1'b1); issue(1'b0, 3'b111, 8'h00, 8'h00, 6'h2A);
    expect_resp(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); issue(1'b0, 3'b111, 8'h00, 8'h00, 6'h15);
    expect_resp(1'b1, 8'h00, 1'b0, 1'b0, 1'b0); issue(1'b1, 3'b110, 8'h12, 8'h34, 6'h00);
    expect_resp(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0); issue(1'b1, 3'b010, 8'h01, 8'h02, 6'h00);
    expect_resp(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0); issue(1'b0, 3'b100, 8'h5A, 8'h00, 6'h00);
    expect_resp(1'b1, 8'h00, 1'b0, 1'b0, 1'b0); issue(1'b1, 3'b000, 8'hFF, 8'hFF, 6'h3F);
    drain();

    // Backpressure: response held, no grants, then IDLE after the take.
    resp_ready = 1'b0;
    expect_resp(1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 3'b001, 8'h7F, 8'h01, 6'h00);
    @(negedge clk);
    req1_instr = 3'b011; req1_A = 8'hFF; req1_B = 8'h0F; req1_baddr = 6'h00; req1_valid = 1'b1;
    expect_resp(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", {19'b0, resp_valid, resp_id, resp_out, resp_co, resp_eq, resp_branch},
            {19'b0, 1'b1, 1'b0, 8'h80, 3'b000});
      check("bp_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_idle", {30'b0, resp_valid, req1_ready}, 32'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    drain();

    // Reset while in EXEC discards the compare and its eq update.
    issue(1'b0, 3'b110, 8'h05, 8'h05, 6'h00);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_exec_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rst_exec_noresp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    expect_resp(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 3'b111, 8'h00, 8'h00, 6'h3F);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be:
- RR_EN, default 1, round-robin arbitration when 1; fixed priority (port 0 wins) when 0.

REQ-002 Ports SHALL be:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- req0_valid, input, 1, requester 0 has an operation.
- req0_ready, output, 1, requester 0 operation accepted this cycle.
- req0_instr, input, 3, requester 0 opcode.
- req0_A, input, 8, requester 0 operand A.
- req0_B, input, 8, requester 0 operand B.
- req0_baddr, input, 6, requester 0 branch target.
- req1_valid, req1_ready, req1_instr, req1_A, req1_B, req1_baddr: same directions, widths and meanings for requester 1.
- resp_valid, output, 1, response held.
- resp_ready, input, 1, consumer takes the response.
- resp_id, output, 1, requester that owns the response.
- resp_out, output, 8, result.
- resp_co, output, 1, carry/borrow.
- resp_eq, output, 1, equality flag.
- resp_branch, output, 1, branch-op indicator.

REQ-003 Reset SHALL be synchronous and active-high on rst, with the single clock clk.

Function
REQ-004 The FSM SHALL have states IDLE, EXEC and RESP, and SHALL reset to IDLE.
REQ-005 In IDLE, at most one reqN_ready SHALL be high, combinationally, for the granted requester.
- If only one requester is valid, that requester is granted.
- If both are valid, the requester selected by the priority pointer is granted.
REQ-006 When a request is accepted (valid & ready), the arbiter SHALL latch the opcode, A, B, baddr and requester id, then move to EXEC.
REQ-007 In EXEC, the arbiter SHALL compute the result, register it into the resp_* outputs, set resp_valid, and move to RESP. Response latency is exactly 2 cycles after the accept edge.
REQ-008 In RESP, all resp_* outputs SHALL hold stable until resp_valid & resp_ready. On that edge resp_valid clears and the FSM returns to IDLE. No new accept occurs in that same cycle.
REQ-009 Opcodes SHALL be:
- 000: nop; out 0, all flags 0.
- 001: add; {co,out} = A+B as a 9-bit result.
- 010: sub; {co,out} = A-B as 9-bit, co = borrow.
- 011: and.
- 100: not A.
- 101: or.
- 110: compare; out = 1 and eq = 1 when A==B, else out = 0 and eq = 0.
- 111: branch; branch = 1; out = {2'b00,baddr} if the owner's stored eq bit is 1, else out = 0.
REQ-010 Flags not named for an opcode SHALL be 0.
REQ-011 The arbiter SHALL keep one stored eq bit per requester.
- Opcode 110 updates the owner's bit with the compare result.
- Any other opcode clears the owner's bit.
- The other requester's bit is never touched.
REQ-012 With RR_EN=1, the priority pointer SHALL point to the requester not granted after each accept. With RR_EN=0, the pointer stays at 0.
REQ-013 A request whose valid drops before it is accepted SHALL be ignored. Requesters SHALL hold valid and operands stable until ready.

Reset
REQ-014 On rst the block SHALL enter IDLE and clear:
- resp_valid, resp_out, resp_co, resp_eq, resp_branch and resp_id to 0;
- both stored eq bits to 0;
- the priority pointer to 0.
REQ-015 An rst asserted in EXEC or RESP SHALL discard the operation in flight, with no response and no eq-bit update.
REQ-016 reqN_ready SHALL be 0 while rst is high.

Structure
REQ-017 A shared package alu_pkg SHALL hold:
- the opcode constants OP_NOP through OP_BR;
- the FSM state encoding;
- the 9-bit sum width constant.
REQ-018 A combinational sub-module alu_core SHALL implement REQ-009. It takes instr, A, B, baddr and eq_in, and produces out, co, eq and branch.

Verification
REQ-019 Add: req0 {001, A=0xF0, B=0x20} -> resp_out 0x10, resp_co 1, resp_id 0, resp_valid exactly 2 cycles after the accept.
REQ-020 Contention: req0 and req1 both valid from reset, RR_EN=1 -> grants alternate 0,1,0,1 across four back-to-back operations. With RR_EN=0 -> requester 0 is always granted.
REQ-021 Branch isolation:
- req0 {110, 0x33, 0x33} -> resp_eq 1.
- req1 {111, baddr=0x2A} -> resp_out 0x00, resp_branch 1.
- req0 {111, baddr=0x2A} -> resp_out 0x2A, resp_branch 1.
REQ-022 Backpressure: resp_ready held low for 5 cycles -> resp_* stable, both readies 0; on the resp_ready=1 cycle -> IDLE next cycle.
REQ-023 Reset in EXEC: rst pulsed one cycle after the accept of {110, 5, 5} -> no resp_valid; a subsequent {111, baddr=0x3F} returns resp_out 0.
REQ-024 Sub borrow: {010, A=0x01, B=0x02} -> resp_out 0xFF, resp_co 1.
